reorder_buffer: RTL and testbench
=================================

# reorder_buffer

Circular reorder buffer that allocates the rename tags the register file stores as Q values and retires results in program order. It drives the register file's commit port and its `control_hazard` flush. It accepts one issue, one writeback and one commit per cycle. Tag 0 means "no producer", so it holds 2**Q_WIDTH-1 entries tagged 1..2**Q_WIDTH-1.

## Interface
- `Q_WIDTH`, 4: tag width; entry count is 2**Q_WIDTH-1 (15).
- `REG_ADDR_WIDTH`, 5: architectural register index width.

- `clk_in` in 1: the single clock.
- `rst_in` in 1: asynchronous, active-high reset.
- `rdy_in` in 1: global enable; when low, all state and outputs hold.
- `issue_valid` in 1: allocate an entry this cycle.
- `issue_rd` in REG_ADDR_WIDTH: destination register; 0 means no register write (branch or store).
- `issue_is_branch` in 1: entry is a conditional branch or jump.
- `alloc_tag` out Q_WIDTH: tag the next issue receives; the register file samples it as `Q_value`.
- `rob_full` out 1: all entries are occupied.
- `wb_valid` in 1: a result is broadcast this cycle.
- `wb_tag` in Q_WIDTH: tag of the producing entry.
- `wb_value` in 32: result value.
- `wb_mispredict` in 1: the branch resolved against its prediction.
- `wb_target_pc` in 32: correct next PC for a mispredicted branch.
- `q1`, `q2` in Q_WIDTH: operand tags to look up.
- `ready1`, `ready2` out 1: the looked-up entry has its value.
- `value1`, `value2` out 32: value of the looked-up entry.
- `has_commit` out 1: one retirement is presented this cycle.
- `commit_target` out REG_ADDR_WIDTH: rd of the retiring entry.
- `Commit_Q` out Q_WIDTH: tag of the retiring entry.
- `Commit_V` out 32: value of the retiring entry.
- `control_hazard` out 1: flush pulse for the register file and the front end.
- `redirect_pc` out 32: fetch target, valid while `control_hazard` is high.

## Operation
- Per-entry state: busy, ready, rd, is_branch, mispredict, value, target_pc. Pointers `head` and `tail` range over 1..15; `count` ranges over 0..15.
- **Wrap:** incrementing a pointer takes 15 to 1. Tag 0 is never allocated.
- **Issue:** when `issue_valid` is high, `rob_full` is low and `control_hazard` is low, write entry[tail] with busy=1 and ready=0, then advance tail. In any other case the issue is dropped silently.
- **Writeback:** when `wb_valid` is high, entry[wb_tag] is busy and `control_hazard` is low, set ready=1 and latch value, mispredict and target_pc. A writeback to a non-busy tag or to tag 0 is ignored.
- **Lookup (combinational):**
  - `readyN` = (busy[qN] & ready[qN]) | (wb_valid & wb_tag==qN & qN!=0).
  - `valueN` comes from the writeback bus on the bypass path, otherwise from entry[qN].
  - qN=0 gives ready 0 and value 0.
- **Commit, registered outputs:** at each enabled edge:
  - If entry[head] is busy and ready: load `has_commit`=1, `commit_target`=rd, `Commit_Q`=head, `Commit_V`=value; clear busy; advance head.
  - Otherwise load `has_commit`=0. The other commit outputs hold.
- **Mispredict:** committing an entry with is_branch & mispredict also loads `control_hazard`=1 and `redirect_pc`=target_pc. At the same edge, clear every busy bit and set head=tail=1, count=0. `control_hazard` is cleared at the next enabled edge.
- **Count:** count changes by +1 for an accepted issue and -1 for a commit. Both in one cycle leaves it unchanged.
- `rob_full` = (count==15). `alloc_tag` = tail.

## Timing
- Reset values, asynchronous: all busy bits 0, head=tail=1, count=0. Outputs: `alloc_tag`=1, `rob_full`=0, `has_commit`=0, `commit_target`=0, `Commit_Q`=0, `Commit_V`=0, `control_hazard`=0, `redirect_pc`=0.
- Writeback at edge N makes the entry ready. If it is head, `has_commit` goes high after edge N+1, and the register file writes at edge N+2.
- Sustained throughput is 1 commit per cycle.
- When full, issue is blocked the same cycle, even if a commit frees an entry at that edge.
- An issue in the same cycle as a mispredict commit is discarded by the flush. Issue and writeback are ignored while `control_hazard` is high.
- Asserting `rst_in` mid-operation empties the buffer immediately, with no commit output.
- While `rdy_in` is low, nothing advances and the registered outputs hold their values.

## Test plan
- **Reset, then issue** rd=5 and rd=6 → `alloc_tag` steps 1, 2, 3. Writeback tag1 value 0xAAAA → one cycle later `has_commit`=1, `commit_target`=5, `Commit_Q`=1, `Commit_V`=0xAAAA.
- **Out-of-order writeback:** tag2 written back before tag1 → no commit until tag1 is ready. Then tags 1 and 2 commit on consecutive cycles, in order.
- **Full and wrap:** issue 16 times → the 16th is dropped, `rob_full`=1, `alloc_tag`=1. Retire 3 entries, issue 2 → new tags 1 and 2 after wrapping past 15.
- **Mispredict:** branch at tag 3 with younger tags 4 and 5 → `control_hazard`=1 and `redirect_pc`=0x1000 for one cycle. The buffer is empty, `alloc_tag`=1, and a later writeback to tag 4 is ignored.
- **Lookup bypass:** with `q1`=2 and `wb_valid`/`wb_tag`=2/`wb_value`=0x55 in the same cycle → `ready1`=1, `value1`=0x55. With `q2`=0 → `ready2`=0.
- **Stall and reset:** hold `rdy_in` low for 3 cycles with a ready head → outputs frozen and no commit. Pulse `rst_in` mid-stream → all outputs immediately return to their reset values.

Source files
------------

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: hands out rename tags 1..2**Q_WIDTH-1, collects
// writebacks out of order and retires one result per cycle in program order.

module reorder_buffer_entry #(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      alloc,
    input  logic [REG_ADDR_WIDTH-1:0] alloc_rd,
    input  logic                      alloc_br,
    input  logic                      wb,
    input  logic [31:0]               wb_value,
    input  logic                      wb_mispredict,
    input  logic [31:0]               wb_target_pc,
    input  logic                      retire,
    input  logic                      flush,
    output logic                      busy,
    output logic                      ready,
    output logic [REG_ADDR_WIDTH-1:0] rd,
    output logic                      is_branch,
    output logic                      mispredict,
    output logic [31:0]               value,
    output logic [31:0]               target_pc
);

    // All strobes arrive already qualified by the global enable.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy       <= 1'b0;
            ready      <= 1'b0;
            rd         <= '0;
            is_branch  <= 1'b0;
            mispredict <= 1'b0;
            value      <= '0;
            target_pc  <= '0;
        end else if (flush) begin
            busy <= 1'b0;
        end else if (alloc) begin
            busy       <= 1'b1;
            ready      <= 1'b0;
            rd         <= alloc_rd;
            is_branch  <= alloc_br;
            mispredict <= 1'b0;
        end else begin
            if (retire)
                busy <= 1'b0;
            if (wb) begin
                ready      <= 1'b1;
                value      <= wb_value;
                mispredict <= wb_mispredict;
                target_pc  <= wb_target_pc;
            end
        end
    end

endmodule

module reorder_buffer #(
    parameter int Q_WIDTH        = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    input  logic                      issue_is_branch,
    output logic [Q_WIDTH-1:0]        alloc_tag,
    output logic                      rob_full,
    input  logic                      wb_valid,
    input  logic [Q_WIDTH-1:0]        wb_tag,
    input  logic [31:0]               wb_value,
    input  logic                      wb_mispredict,
    input  logic [31:0]               wb_target_pc,
    input  logic [Q_WIDTH-1:0]        q1,
    input  logic [Q_WIDTH-1:0]        q2,
    output logic                      ready1,
    output logic                      ready2,
    output logic [31:0]               value1,
    output logic [31:0]               value2,
    output logic                      has_commit,
    output logic [REG_ADDR_WIDTH-1:0] commit_target,
    output logic [Q_WIDTH-1:0]        Commit_Q,
    output logic [31:0]               Commit_V,
    output logic                      control_hazard,
    output logic [31:0]               redirect_pc
);

    localparam int                 DEPTH = 1 << Q_WIDTH;
    localparam logic [Q_WIDTH-1:0] LAST  = '1;
    localparam logic [Q_WIDTH-1:0] FIRST = Q_WIDTH'(1);

    // Slot 0 is a constant empty entry so tag 0 lookups fall out naturally.
    logic [DEPTH-1:0]                     busy_q, ready_q, br_q, mis_q;
    logic [DEPTH-1:0][REG_ADDR_WIDTH-1:0] rd_q;
    logic [DEPTH-1:0][31:0]               value_q, tpc_q;

    logic [Q_WIDTH-1:0] head, tail, count;
    logic               issue_acc, wb_acc, commit_go, flush;
    logic               bypass1, bypass2;

    function automatic logic [Q_WIDTH-1:0] next_ptr(input logic [Q_WIDTH-1:0] p);
        return (p == LAST) ? FIRST : p + FIRST;
    endfunction

    assign rob_full  = (count == LAST);
    assign alloc_tag = tail;

    assign issue_acc = rdy_in & issue_valid & ~rob_full & ~control_hazard;
    assign wb_acc    = rdy_in & wb_valid & (wb_tag != '0) & busy_q[wb_tag] & ~control_hazard;
    assign commit_go = rdy_in & busy_q[head] & ready_q[head];
    assign flush     = commit_go & br_q[head] & mis_q[head];

    assign busy_q[0]  = 1'b0;
    assign ready_q[0] = 1'b0;
    assign br_q[0]    = 1'b0;
    assign mis_q[0]   = 1'b0;
    assign rd_q[0]    = '0;
    assign value_q[0] = '0;
    assign tpc_q[0]   = '0;

    for (genvar i = 1; i < DEPTH; i++) begin : g_entry
        reorder_buffer_entry #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_entry (
            .clk_in        (clk_in),
            .rst_in        (rst_in),
            .alloc         (issue_acc & (tail == Q_WIDTH'(i))),
            .alloc_rd      (issue_rd),
            .alloc_br      (issue_is_branch),
            .wb            (wb_acc & (wb_tag == Q_WIDTH'(i))),
            .wb_value      (wb_value),
            .wb_mispredict (wb_mispredict),
            .wb_target_pc  (wb_target_pc),
            .retire        (commit_go & (head == Q_WIDTH'(i))),
            .flush         (flush),
            .busy          (busy_q[i]),
            .ready         (ready_q[i]),
            .rd            (rd_q[i]),
            .is_branch     (br_q[i]),
            .mispredict    (mis_q[i]),
            .value         (value_q[i]),
            .target_pc     (tpc_q[i])
        );
    end

    // Operand lookup with same-cycle forwarding from the writeback bus.
    assign bypass1 = wb_valid & (wb_tag == q1) & (q1 != '0);
    assign bypass2 = wb_valid & (wb_tag == q2) & (q2 != '0);
    assign ready1  = (busy_q[q1] & ready_q[q1]) | bypass1;
    assign ready2  = (busy_q[q2] & ready_q[q2]) | bypass2;
    assign value1  = bypass1 ? wb_value : value_q[q1];
    assign value2  = bypass2 ? wb_value : value_q[q2];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head           <= FIRST;
            tail           <= FIRST;
            count          <= '0;
            has_commit     <= 1'b0;
            commit_target  <= '0;
            Commit_Q       <= '0;
            Commit_V       <= '0;
            control_hazard <= 1'b0;
            redirect_pc    <= '0;
        end else if (rdy_in) begin
            has_commit     <= commit_go;
            control_hazard <= flush;
            if (commit_go) begin
                commit_target <= rd_q[head];
                Commit_Q      <= head;
                Commit_V      <= value_q[head];
            end
            if (flush) begin
                // A same-cycle issue is discarded along with the younger entries.
                redirect_pc <= tpc_q[head];
                head        <= FIRST;
                tail        <= FIRST;
                count       <= '0;
            end else begin
                if (commit_go)
                    head <= next_ptr(head);
                if (issue_acc)
                    tail <= next_ptr(tail);
                if (issue_acc && !commit_go)
                    count <= count + FIRST;
                else if (!issue_acc && commit_go)
                    count <= count - FIRST;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: expected retirements are queued with the
// stimulus and a negedge monitor checks every commit the DUT presents.

module tb_reorder_buffer;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_is_branch = 1'b0;
    logic [3:0]  alloc_tag;
    logic        rob_full;
    logic        wb_valid = 1'b0;
    logic [3:0]  wb_tag = '0;
    logic [31:0] wb_value = '0;
    logic        wb_mispredict = 1'b0;
    logic [31:0] wb_target_pc = '0;
    logic [3:0]  q1 = '0, q2 = '0;
    logic        ready1, ready2;
    logic [31:0] value1, value2;
    logic        has_commit;
    logic [4:0]  commit_target;
    logic [3:0]  Commit_Q;
    logic [31:0] Commit_V;
    logic        control_hazard;
    logic [31:0] redirect_pc;

    typedef struct {
        logic [4:0]  rd;
        logic [3:0]  tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic en_q    = 1'b0;

    reorder_buffer #(.Q_WIDTH(4), .REG_ADDR_WIDTH(5)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_branch(issue_is_branch),
        .alloc_tag(alloc_tag), .rob_full(rob_full),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
        .wb_mispredict(wb_mispredict), .wb_target_pc(wb_target_pc),
        .q1(q1), .q2(q2), .ready1(ready1), .ready2(ready2), .value1(value1), .value2(value2),
        .has_commit(has_commit), .commit_target(commit_target), .Commit_Q(Commit_Q),
        .Commit_V(Commit_V), .control_hazard(control_hazard), .redirect_pc(redirect_pc)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Remember whether the last edge was enabled so a frozen commit is not counted twice.
    always @(posedge clk_in) en_q <= rdy_in;

    always @(negedge clk_in) begin
        if (!rst_in && en_q && has_commit) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_commit: got tag %0h expected none", Commit_Q);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_Commit_Q", 32'(Commit_Q), 32'(e.tag));
                chk("mon_commit_target", 32'(commit_target), 32'(e.rd));
                chk("mon_Commit_V", Commit_V, e.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push(input logic [4:0] rd, input logic [3:0] tag, input logic [31:0] val);
        exp_t e;
        e.rd = rd; e.tag = tag; e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic br);
        issue_valid = 1'b1; issue_rd = rd; issue_is_branch = br;
        tick();
        issue_valid = 1'b0; issue_is_branch = 1'b0;
    endtask

    task automatic do_wb(input logic [3:0] tag, input logic [31:0] val,
                         input logic mis, input logic [31:0] pc);
        wb_valid = 1'b1; wb_tag = tag; wb_value = val; wb_mispredict = mis; wb_target_pc = pc;
        tick();
        wb_valid = 1'b0; wb_mispredict = 1'b0;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_alloc_tag"}, 32'(alloc_tag), 32'd1);
        chk({tag, "_rob_full"}, 32'(rob_full), 32'd0);
        chk({tag, "_has_commit"}, 32'(has_commit), 32'd0);
        chk({tag, "_commit_target"}, 32'(commit_target), 32'd0);
        chk({tag, "_Commit_Q"}, 32'(Commit_Q), 32'd0);
        chk({tag, "_Commit_V"}, Commit_V, 32'd0);
        chk({tag, "_control_hazard"}, 32'(control_hazard), 32'd0);
        chk({tag, "_redirect_pc"}, redirect_pc, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        rst_in = 1'b0;
        chk_reset_outputs("rst");

        // Basic issue and in-order commit
        push(5'd5, 4'd1, 32'hAAAA);
        do_issue(5'd5, 1'b0);
        chk("t1_alloc2", 32'(alloc_tag), 32'd2);
        push(5'd6, 4'd2, 32'hBBBB);
        do_issue(5'd6, 1'b0);
        chk("t1_alloc3", 32'(alloc_tag), 32'd3);
        do_wb(4'd1, 32'hAAAA, 1'b0, 32'h0);
        chk("t1_no_commit_yet", 32'(has_commit), 32'd0);
        do_wb(4'd2, 32'hBBBB, 1'b0, 32'h0);
        chk("t1_has_commit", 32'(has_commit), 32'd1);
        chk("t1_commit_target", 32'(commit_target), 32'd5);
        chk("t1_Commit_Q", 32'(Commit_Q), 32'd1);
        chk("t1_Commit_V", Commit_V, 32'hAAAA);
        tick();
        chk("t1_second_Q", 32'(Commit_Q), 32'd2);
        tick();
        chk("t1_idle", 32'(has_commit), 32'd0);

        // Out-of-order writeback: tags 3,4 with 4 resolving first
        push(5'd7, 4'd3, 32'h33);
        do_issue(5'd7, 1'b0);
        push(5'd8, 4'd4, 32'h44);
        do_issue(5'd8, 1'b0);
        do_wb(4'd4, 32'h44, 1'b0, 32'h0);
        tick();
        tick();
        chk("t2_blocked", 32'(has_commit), 32'd0);
        do_wb(4'd3, 32'h33, 1'b0, 32'h0);
        tick();
        chk("t2_first_Q", 32'(Commit_Q), 32'd3);
        tick();
        chk("t2_second_hc", 32'(has_commit), 32'd1);
        chk("t2_second_Q", 32'(Commit_Q), 32'd4);
        tick();
        chk("t2_idle", 32'(has_commit), 32'd0);

        // Fill, overflow, block-while-full and wrap
        do_reset();
        for (int i = 1; i <= 15; i++) begin
            if (i <= 3) push(5'(i), 4'(i), 32'h100 + 32'(i));
            do_issue(5'(i), 1'b0);
        end
        chk("t3_full", 32'(rob_full), 32'd1);
        chk("t3_alloc_wrap", 32'(alloc_tag), 32'd1);
        do_issue(5'd16, 1'b0);
        chk("t3_drop_alloc", 32'(alloc_tag), 32'd1);
        chk("t3_drop_full", 32'(rob_full), 32'd1);
        do_wb(4'd1, 32'h101, 1'b0, 32'h0);
        issue_valid = 1'b1; issue_rd = 5'd20;
        do_wb(4'd2, 32'h102, 1'b0, 32'h0);
        issue_valid = 1'b0;
        chk("t3_block_same_cycle", 32'(alloc_tag), 32'd1);
        chk("t3_not_full", 32'(rob_full), 32'd0);
        do_wb(4'd3, 32'h103, 1'b0, 32'h0);
        tick();
        chk("t3_alloc_before", 32'(alloc_tag), 32'd1);
        do_issue(5'd21, 1'b0);
        chk("t3_wrap_tag1", 32'(alloc_tag), 32'd2);
        do_issue(5'd22, 1'b0);
        chk("t3_wrap_tag2", 32'(alloc_tag), 32'd3);
        chk("t3_rob_full", 32'(rob_full), 32'd0);

        // Mispredicted branch at tag 3 with younger 4 and 5
        do_reset();
        push(5'd1, 4'd1, 32'h11);
        do_issue(5'd1, 1'b0);
        push(5'd2, 4'd2, 32'h22);
        do_issue(5'd2, 1'b0);
        push(5'd0, 4'd3, 32'h0);
        do_issue(5'd0, 1'b1);
        do_issue(5'd4, 1'b0);
        do_issue(5'd5, 1'b0);
        do_wb(4'd4, 32'h44, 1'b0, 32'h0);
        do_wb(4'd1, 32'h11, 1'b0, 32'h0);
        do_wb(4'd2, 32'h22, 1'b0, 32'h0);
        do_wb(4'd3, 32'h0, 1'b1, 32'h1000);
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        chk("t4_hazard", 32'(control_hazard), 32'd1);
        chk("t4_redirect", redirect_pc, 32'h1000);
        chk("t4_alloc_reset", 32'(alloc_tag), 32'd1);
        chk("t4_branch_Q", 32'(Commit_Q), 32'd3);
        tick();
        issue_valid = 1'b0;
        chk("t4_hazard_pulse", 32'(control_hazard), 32'd0);
        chk("t4_issue_in_hazard", 32'(alloc_tag), 32'd1);
        do_wb(4'd4, 32'h99, 1'b0, 32'h0);
        tick();
        tick();
        chk("t4_stale_wb", 32'(has_commit), 32'd0);
        q1 = 4'd4;
        #1;
        chk("t4_tag4_not_ready", 32'(ready1), 32'd0);

        // Lookup and bypass
        push(5'd1, 4'd1, 32'h77);
        do_issue(5'd1, 1'b0);
        push(5'd2, 4'd2, 32'h55);
        do_issue(5'd2, 1'b0);
        q1 = 4'd2; q2 = 4'd0;
        #1;
        chk("t5_not_ready", 32'(ready1), 32'd0);
        wb_valid = 1'b1; wb_tag = 4'd2; wb_value = 32'h55;
        #1;
        chk("t5_bypass_ready", 32'(ready1), 32'd1);
        chk("t5_bypass_value", value1, 32'h55);
        chk("t5_q0_ready", 32'(ready2), 32'd0);
        chk("t5_q0_value", value2, 32'd0);
        tick();
        wb_valid = 1'b0;
        #1;
        chk("t5_stored_ready", 32'(ready1), 32'd1);
        chk("t5_stored_value", value1, 32'h55);
        do_wb(4'd1, 32'h77, 1'b0, 32'h0);
        tick();
        tick();
        tick();

        // Stall with a commit on the outputs, then release
        push(5'd10, 4'd3, 32'hC3);
        do_issue(5'd10, 1'b0);
        push(5'd11, 4'd4, 32'hC4);
        do_issue(5'd11, 1'b0);
        do_wb(4'd4, 32'hC4, 1'b0, 32'h0);
        do_wb(4'd3, 32'hC3, 1'b0, 32'h0);
        tick();
        chk("t6_pre_Q", 32'(Commit_Q), 32'd3);
        rdy_in = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd13;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_frozen_hc", 32'(has_commit), 32'd1);
            chk("t6_frozen_Q", 32'(Commit_Q), 32'd3);
            chk("t6_frozen_alloc", 32'(alloc_tag), 32'd5);
        end
        issue_valid = 1'b0;
        rdy_in = 1'b1;
        tick();
        chk("t6_resume_Q", 32'(Commit_Q), 32'd4);
        tick();
        chk("t6_idle", 32'(has_commit), 32'd0);

        // Asynchronous reset mid-stream with a ready head
        do_issue(5'd12, 1'b0);
        do_wb(4'd5, 32'h5, 1'b0, 32'h0);
        #2;
        rst_in = 1'b1;
        #1;
        chk_reset_outputs("t7");
        tick();
        tick();
        rst_in = 1'b0;
        tick();
        tick();
        chk("t7_no_commit", 32'(has_commit), 32'd0);
        chk("end_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
